bsram_arbiter: RTL

Shares one single-port-style BSRAM instance between two requesters: port 0 is instruction fetch and port 1 is data load/store. Arbitration is round-robin, with at most one memory access per cycle. Read data is registered and returned one cycle after grant. The block also contains a clear sequencer that zero-fills the whole memory on command. It sits between the core's fetch/memory stages and the BSRAM read/write ports.

---
 rtl/bsram_arbiter_pkg.sv | 13 +
 rtl/bsram_arbiter_rr_arbiter2.sv | 44 ++++
 rtl/bsram_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/bsram_arbiter_pkg.sv
// Shared definitions for the BSRAM arbiter: the default word and address sizes
// used with the BSRAM, and the RUN/CLEAR state encoding.
package bsram_arbiter_pkg;

   localparam int BSRAM_DATA_WIDTH = 32;
   localparam int BSRAM_ADDR_WIDTH = 8;

   typedef enum logic {
      RUN   = 1'b0,
      CLEAR = 1'b1
   } state_e;

endpackage

// File: rtl/bsram_arbiter_rr_arbiter2.sv
// Two-input round-robin arbiter. Produces one-hot combinational grants and
// remembers which port won most recently, so contention alternates.
module rr_arbiter2
   import bsram_arbiter_pkg::*;
(
   input  logic clock,
   input  logic reset,
   input  logic en,
   input  logic req0,
   input  logic req1,
   output logic gnt0,
   output logic gnt1
);

   logic last_q, last_d;

   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (en) begin
         if (req0 && req1) begin
            gnt0 = last_q;
            gnt1 = ~last_q;
         end else begin
            gnt0 = req0;
            gnt1 = req1;
         end
      end
      // The winner is remembered only on cycles where a grant is issued.
      last_d = last_q;
      if (gnt0)
         last_d = 1'b0;
      else if (gnt1)
         last_d = 1'b1;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         last_q <= 1'b1;
      else
         last_q <= last_d;
   end

endmodule

// File: rtl/bsram_arbiter.sv
// Shares one BSRAM between instruction fetch (port 0) and data access (port 1),
// one access per cycle, and zero-fills the whole memory on a clear pulse.
module bsram_arbiter
   import bsram_arbiter_pkg::*;
#(
   parameter int CORE       = 0,
   parameter int DATA_WIDTH = BSRAM_DATA_WIDTH,
   parameter int ADDR_WIDTH = BSRAM_ADDR_WIDTH
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  clear,
   output logic                  busy,
   input  logic                  req0,
   input  logic                  req1,
   input  logic                  we0,
   input  logic                  we1,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [ADDR_WIDTH-1:0] addr1,
   input  logic [DATA_WIDTH-1:0] wdata0,
   input  logic [DATA_WIDTH-1:0] wdata1,
   output logic                  gnt0,
   output logic                  gnt1,
   output logic                  rvalid0,
   output logic                  rvalid1,
   output logic [DATA_WIDTH-1:0] rdata0,
   output logic [DATA_WIDTH-1:0] rdata1,
   output logic                  mem_readEnable,
   output logic [ADDR_WIDTH-1:0] mem_readAddress,
   input  logic [DATA_WIDTH-1:0] mem_readData,
   output logic                  mem_writeEnable,
   output logic [ADDR_WIDTH-1:0] mem_writeAddress,
   output logic [DATA_WIDTH-1:0] mem_writeData,
   input  logic                  report
);

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic                  rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
   logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
   logic [31:0]           cycle_q, cycle_d;
   logic                  arb_en, rd0, rd1;

   // Grants are held off during CLEAR and while reset is asserted.
   assign arb_en = (state_q == RUN) && reset;

   rr_arbiter2 u_arb (
      .clock (clock),
      .reset (reset),
      .en    (arb_en),
      .req0  (req0),
      .req1  (req1),
      .gnt0  (gnt0),
      .gnt1  (gnt1)
   );

   assign rd0 = gnt0 && !we0;
   assign rd1 = gnt1 && !we1;

   always_comb begin
      state_d          = state_q;
      cnt_d            = cnt_q;
      cycle_d          = cycle_q + 32'd1;
      rvalid0_d        = rd0;
      rvalid1_d        = rd1;
      rdata0_d         = rd0 ? mem_readData : rdata0_q;
      rdata1_d         = rd1 ? mem_readData : rdata1_q;
      mem_readEnable   = 1'b0;
      mem_readAddress  = '0;
      mem_writeEnable  = 1'b0;
      mem_writeAddress = '0;
      mem_writeData    = '0;
      case (state_q)
         RUN: begin
            if (gnt0) begin
               mem_readEnable   = !we0;
               mem_readAddress  = we0 ? '0 : addr0;
               mem_writeEnable  = we0;
               mem_writeAddress = we0 ? addr0 : '0;
               mem_writeData    = we0 ? wdata0 : '0;
            end else if (gnt1) begin
               mem_readEnable   = !we1;
               mem_readAddress  = we1 ? '0 : addr1;
               mem_writeEnable  = we1;
               mem_writeAddress = we1 ? addr1 : '0;
               mem_writeData    = we1 ? wdata1 : '0;
            end
            if (clear) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end
         end
         CLEAR: begin
            mem_writeEnable  = 1'b1;
            mem_writeAddress = cnt_q;
            cnt_d            = cnt_q + 1'b1;
            // Single pass: stop after the last address instead of wrapping.
            if (cnt_q == '1) begin
               state_d = RUN;
               cnt_d   = '0;
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= RUN;
         cnt_q     <= '0;
         cycle_q   <= '0;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
         rdata0_q  <= '0;
         rdata1_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         cycle_q   <= cycle_d;
         rvalid0_q <= rvalid0_d;
         rvalid1_q <= rvalid1_d;
         rdata0_q  <= rdata0_d;
         rdata1_q  <= rdata1_d;
      end
   end

   assign busy    = (state_q == CLEAR);
   assign rvalid0 = rvalid0_q;
   assign rvalid1 = rvalid1_q;
   assign rdata0  = rdata0_q;
   assign rdata1  = rdata1_q;

`ifndef SYNTHESIS
   always @(posedge clock) begin
      if (reset && report)
         $display("[core %0d] cycle %0d state %s req %b%b gnt %b%b cnt %0d",
                  CORE, cycle_q, (state_q == CLEAR) ? "CLEAR" : "RUN",
                  req1, req0, gnt1, gnt0, cnt_q);
   end
`endif

endmodule
